cvrt_gry2bin_pipe: RTL and testbench

Pipelined Gray-to-binary decoder with a valid/ready stream interface. It is the receive-side counterpart of the binary-to-Gray converter: it decodes Gray-coded counters and pointers back to binary.
An optional step checker flags any accepted word whose Gray code differs from the previous accepted word in more than one bit.
It sits at the consumer end of Gray-coded pointer/counter paths, for example FIFO pointer compare and position decode.

---
 rtl/cvrt_pkg.sv | 26 ++
 rtl/cvrt_gry2bin_stg.sv | 67 ++++++
 rtl/cvrt_gry2bin_pipe.sv | 139 +++++++++++++
 tb/tb_cvrt_gry2bin_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvrt_pkg.sv
// Shared constants and helpers for the pipelined Gray-to-binary decoder.
// Word widths above CVRT_MAX_W are not supported by the step checker.
package cvrt_pkg;

   localparam int unsigned CVRT_MAX_W = 256;

   function automatic int unsigned cvrt_chunk(input int unsigned width, input int unsigned stages);
      return (width + stages - 32'd1) / stages;
   endfunction

   // Highest bit resolved by stage idx; negative when the stage has nothing left to do.
   function automatic int cvrt_hi(input int width, input int chunk, input int idx);
      return width - 32'sd1 - idx * chunk;
   endfunction

   function automatic int cvrt_lo(input int width, input int chunk, input int idx);
      int lo;
      lo = cvrt_hi(width, chunk, idx) - chunk + 32'sd1;
      return (lo < 32'sd0) ? 32'sd0 : lo;
   endfunction

   function automatic logic popcnt_gt1(input logic [CVRT_MAX_W-1:0] vec);
      return |(vec & (vec - {{(CVRT_MAX_W-1){1'b0}}, 1'b1}));
   endfunction

endpackage

// File: rtl/cvrt_gry2bin_stg.sv
// One elastic stage of the Gray-to-binary pipeline: resolves its chunk of
// binary bits from the Gray remainder and registers the payload.
module cvrt_gry2bin_stg
   import cvrt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CHUNK      = 8,
   parameter int unsigned STAGE_IDX  = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic                  i_valid,
   input  logic [2*DATA_WIDTH:0] i_pld,
   output logic                  o_valid,
   output logic [2*DATA_WIDTH:0] o_pld
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] gry_rem;
      logic [DATA_WIDTH-1:0] bin_done;
      logic                  err;
   } pld_t;

   localparam int HI = cvrt_hi(int'(DATA_WIDTH), int'(CHUNK), int'(STAGE_IDX));
   localparam int LO = cvrt_lo(int'(DATA_WIDTH), int'(CHUNK), int'(STAGE_IDX));
   // Binary bit just above this chunk; the MSB chunk starts from 0 instead.
   localparam int CARRY_IDX = ((HI < 0) || (HI >= int'(DATA_WIDTH) - 1)) ? 0 : HI + 1;
   localparam bit CARRY_ZERO = (HI >= int'(DATA_WIDTH) - 1);

   pld_t w_in;
   pld_t w_dec;
   logic w_carry;
   logic r_valid;
   pld_t r_pld;

   // Resolve this stage's chunk MSB-first, consuming the matching Gray bits.
   always_comb begin
      w_in    = pld_t'(i_pld);
      w_dec   = w_in;
      w_carry = CARRY_ZERO ? 1'b0 : w_in.bin_done[CARRY_IDX];
      for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
         if ((i <= HI) && (i >= LO)) begin
            w_carry             = w_carry ^ w_in.gry_rem[i];
            w_dec.bin_done[i]   = w_carry;
            w_dec.gry_rem[i]    = 1'b0;
         end else begin
            w_dec.gry_rem[i]    = w_in.gry_rem[i];
         end
      end
   end

   // Stage register: advances whenever the downstream chain can take a word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_pld   <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_pld   <= w_dec;
      end
   end

   assign o_valid = r_valid;
   assign o_pld   = r_pld;

endmodule

// File: rtl/cvrt_gry2bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready handshake and an
// optional single-bit-step checker whose verdict travels with each word.
module cvrt_gry2bin_pipe
   import cvrt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STAGE_NUM  = 4,
   parameter int unsigned CHK_EN     = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_gry,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_bin,
   output logic                  o_err,
   output logic                  o_err_sticky,
   input  logic                  i_err_clr
);

   localparam int unsigned CHUNK = cvrt_chunk(DATA_WIDTH, STAGE_NUM);
   localparam int unsigned PW    = 2 * DATA_WIDTH + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] gry_rem;
      logic [DATA_WIDTH-1:0] bin_done;
      logic                  err;
   } pld_t;

   logic [STAGE_NUM-1:0] w_vld;
   logic [STAGE_NUM-1:0] w_load;
   logic [PW-1:0]        w_pld [STAGE_NUM];
   pld_t                 w_head;
   logic                 w_step_err;
   logic                 w_full_tail;
   logic                 w_in_xfer;
   logic                 w_out_xfer;
   logic                 r_err_sticky;

   // Stage k stalls only when it and every stage after it are full and the
   // sink is not ready; unrolled this way so no load term feeds another.
   always_comb begin
      w_full_tail = 1'b1;
      w_load      = '0;
      for (int k = int'(STAGE_NUM) - 1; k >= 0; k--) begin
         w_full_tail = w_full_tail & w_vld[k];
         w_load[k]   = i_ready | ~w_full_tail;
      end
   end

   assign o_ready    = w_load[0];
   assign w_in_xfer  = i_valid & w_load[0];
   assign w_out_xfer = o_valid & i_ready;

   generate
      if (CHK_EN != 0) begin : g_chk
         logic                  r_prev_vld;
         logic [DATA_WIDTH-1:0] r_prev_gry;
         logic [CVRT_MAX_W-1:0] w_diff;

         // Zero-extend the step difference to the helper's fixed width.
         always_comb begin
            w_diff                 = '0;
            w_diff[DATA_WIDTH-1:0] = i_gry ^ r_prev_gry;
         end

         assign w_step_err = r_prev_vld & popcnt_gt1(w_diff);

         // Previous accepted word; cleared by reset so the next word is unchecked.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_prev_vld <= 1'b0;
               r_prev_gry <= '0;
            end else if (w_in_xfer) begin
               r_prev_vld <= 1'b1;
               r_prev_gry <= i_gry;
            end
         end
      end else begin : g_nochk
         assign w_step_err = 1'b0;
      end
   endgenerate

   // Head payload: raw Gray word, nothing resolved yet, checker verdict.
   always_comb begin
      w_head         = '0;
      w_head.gry_rem = i_gry;
      w_head.err     = w_step_err;
   end

   generate
      for (genvar k = 0; k < STAGE_NUM; k++) begin : g_stg
         logic          w_vld_in;
         logic [PW-1:0] w_pld_in;

         if (k == 0) begin : g_first
            assign w_vld_in = i_valid;
            assign w_pld_in = w_head;
         end else begin : g_next
            assign w_vld_in = w_vld[k-1];
            assign w_pld_in = w_pld[k-1];
         end

         cvrt_gry2bin_stg #(
            .DATA_WIDTH (DATA_WIDTH),
            .CHUNK      (CHUNK),
            .STAGE_IDX  (k)
         ) u_stg (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (w_load[k]),
            .i_valid (w_vld_in),
            .i_pld   (w_pld_in),
            .o_valid (w_vld[k]),
            .o_pld   (w_pld[k])
         );
      end
   endgenerate

   assign o_valid = w_vld[STAGE_NUM-1];
   assign o_bin   = w_pld[STAGE_NUM-1][DATA_WIDTH:1];
   assign o_err   = (CHK_EN != 0) ? w_pld[STAGE_NUM-1][0] : 1'b0;

   // Sticky error: a delivered error wins over a same-cycle clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err_sticky <= 1'b0;
      end else if (w_out_xfer && o_err) begin
         r_err_sticky <= 1'b1;
      end else if (i_err_clr) begin
         r_err_sticky <= 1'b0;
      end
   end

   assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_cvrt_gry2bin_pipe.sv
// Directed bench for cvrt_gry2bin_pipe with queue scoreboards on a 2-stage
// instance and on 1/3/8-stage instances used for the exhaustive sweep.
module tb_cvrt_gry2bin_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_valid, i_ready, i_err_clr, x_valid;
   logic [7:0] i_gry;
   logic       o_ready, o_valid, o_err, o_err_sticky;
   logic [7:0] o_bin;

   int total = 0;
   int bad   = 0;

   logic [8:0] sb_q[$];
   logic [7:0] m_prev_gry;
   logic       m_prev_vld;

   always #5 clk = ~clk;

   cvrt_gry2bin_pipe #(.DATA_WIDTH(8), .STAGE_NUM(2), .CHK_EN(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_gry(i_gry),
      .o_valid(o_valid), .i_ready(i_ready), .o_bin(o_bin), .o_err(o_err),
      .o_err_sticky(o_err_sticky), .i_err_clr(i_err_clr)
   );

   function automatic logic [7:0] gry2bin(input logic [7:0] g);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   function automatic logic [7:0] bin2gry(input logic [7:0] n);
      return n ^ (n >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the main instance: push on input transfer, pop on output transfer.
   always @(negedge clk) begin : mon_main
      logic [8:0] e;
      if (rst) begin
         sb_q.delete();
         m_prev_vld = 1'b0;
         m_prev_gry = 8'h00;
      end else begin
         if (o_valid && i_ready) begin
            total++;
            assert (sb_q.size() > 0) else begin
               bad++;
               $error("FAIL main_pop: observed output word %h with empty queue, expected none", o_bin);
            end
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("main_bin", 32'(o_bin), 32'(e[8:1]));
               chk("main_err", 32'(o_err), 32'(e[0]));
            end
         end
         if (i_valid && o_ready) begin
            e = {gry2bin(i_gry), m_prev_vld && ($countones(i_gry ^ m_prev_gry) > 1)};
            sb_q.push_back(e);
            m_prev_vld = 1'b1;
            m_prev_gry = i_gry;
         end
      end
   end

   generate
      for (genvar j = 0; j < 3; j++) begin : g_x
         localparam int S = (j == 0) ? 1 : ((j == 1) ? 3 : 8);
         logic       xr, xv, xe, xs;
         logic [7:0] xb;
         logic [8:0] q[$];
         logic [7:0] pg;
         logic       pv;
         int         pend = 0;

         cvrt_gry2bin_pipe #(.DATA_WIDTH(8), .STAGE_NUM(S), .CHK_EN(1)) u_x (
            .i_clk(clk), .i_rst(rst), .i_valid(x_valid), .o_ready(xr), .i_gry(i_gry),
            .o_valid(xv), .i_ready(1'b1), .o_bin(xb), .o_err(xe),
            .o_err_sticky(xs), .i_err_clr(1'b0)
         );

         always @(negedge clk) begin : mon_x
            logic [8:0] e;
            if (rst) begin
               q.delete();
               pend = 0;
               pv   = 1'b0;
               pg   = 8'h00;
            end else begin
               if (xv) begin
                  total++;
                  assert (q.size() > 0) else begin
                     bad++;
                     $error("FAIL x%0d_pop: observed output word %h with empty queue, expected none", S, xb);
                  end
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     pend--;
                     chk($sformatf("x%0d_bin", S), 32'(xb), 32'(e[8:1]));
                     chk($sformatf("x%0d_err", S), 32'(xe), 32'(e[0]));
                  end
               end
               if (x_valid && xr) begin
                  e = {gry2bin(i_gry), pv && ($countones(i_gry ^ pg) > 1)};
                  q.push_back(e);
                  pend++;
                  pv = 1'b1;
                  pg = i_gry;
               end
            end
         end
      end
   endgenerate

   task automatic send(input logic [7:0] g);
      logic ok;
      ok      = 1'b0;
      i_valid = 1'b1;
      i_gry   = g;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (o_ready) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      assert (ok) else begin
         bad++;
         $error("FAIL send_accept: observed o_ready=0 for 50 cycles, expected accept of %h", g);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_out_err(input string tag);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (o_valid && o_err) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      logic done;
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_err_clr = 1'b0; i_gry = 8'h00; x_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_bin", 32'(o_bin), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_sticky", 32'(o_err_sticky), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", 32'(o_ready), 32'd1);

      // 1: back-to-back words, two-cycle latency
      send(8'hC0);
      chk("t1_lat", 32'(o_valid), 32'd0);
      send(8'h80);
      chk("t1_v0", 32'(o_valid), 32'd1);
      chk("t1_b0", 32'(o_bin), 32'h80);
      send(8'h01);
      chk("t1_b1", 32'(o_bin), 32'hFF);
      @(posedge clk); #1;
      chk("t1_b2", 32'(o_bin), 32'h01);
      chk("t1_e2", 32'(o_err), 32'd1);
      @(posedge clk); #1;
      chk("t1_drain", 32'(o_valid), 32'd0);

      // 2: step checker, sticky rises after the offending transfer
      pulse_rst();
      send(8'h00); send(8'h01); send(8'h03); send(8'h00);
      wait_out_err("t2_err_seen");
      chk("t2_sticky_pre", 32'(o_err_sticky), 32'd0);
      @(posedge clk); #1;
      chk("t2_sticky_post", 32'(o_err_sticky), 32'd1);

      // 3: backpressure for 5 cycles
      i_ready = 1'b0;
      i_valid = 1'b1; i_gry = 8'h10;
      @(posedge clk); #1;
      i_gry = 8'h30;
      @(posedge clk); #1;
      i_gry = 8'h70;
      chk("t3_ready_low", 32'(o_ready), 32'd0);
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         chk("t3_hold_v", 32'(o_valid), 32'd1);
         chk("t3_hold_b", 32'(o_bin), 32'h1F);
         chk("t3_hold_r", 32'(o_ready), 32'd0);
      end
      i_ready = 1'b1;
      #1;
      chk("t3_ready_back", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      chk("t3_b1", 32'(o_bin), 32'h20);
      i_gry = 8'hF0;
      @(posedge clk); #1;
      chk("t3_b2", 32'(o_bin), 32'h5F);
      i_valid = 1'b0;
      @(posedge clk); #1;
      chk("t3_b3", 32'(o_bin), 32'hA0);
      @(posedge clk); #1;
      chk("t3_empty_v", 32'(o_valid), 32'd0);
      chk("t3_none_lost", 32'(sb_q.size()), 32'd0);

      // 4: clear coinciding with an error transfer
      i_err_clr = 1'b1;
      @(posedge clk); #1;
      chk("t4_clr_alone", 32'(o_err_sticky), 32'd0);
      i_err_clr = 1'b0;
      send(8'hF1); send(8'h0E);
      wait_out_err("t4_err_seen");
      i_err_clr = 1'b1;
      @(posedge clk); #1;
      chk("t4_set_wins", 32'(o_err_sticky), 32'd1);
      @(posedge clk); #1;
      chk("t4_clear", 32'(o_err_sticky), 32'd0);
      i_err_clr = 1'b0;

      // 5: reset with two words in flight
      send(8'h3C); send(8'h00);
      chk("t5_inflight", 32'(o_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_async_drop", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         chk("t5_nothing", 32'(o_valid), 32'd0);
      end
      send(8'hFF);
      @(posedge clk); #1;
      chk("t5_v", 32'(o_valid), 32'd1);
      chk("t5_bin", 32'(o_bin), 32'hAA);
      chk("t5_err", 32'(o_err), 32'd0);
      @(posedge clk); #1;

      // 6: exhaustive counter sweep with wrap on all instances
      pulse_rst();
      x_valid = 1'b1;
      for (int n = 0; n <= 256; n++) begin
         logic [7:0] nb;
         nb = 8'(n);
         send(bin2gry(nb));
      end
      x_valid = 1'b0;
      done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && g_x[0].pend == 0 && g_x[1].pend == 0 && g_x[2].pend == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("t6_drained", 32'(done), 32'd1);
      chk("t6_main_sticky", 32'(o_err_sticky), 32'd0);
      chk("t6_x1_sticky", 32'(g_x[0].xs), 32'd0);
      chk("t6_x3_sticky", 32'(g_x[1].xs), 32'd0);
      chk("t6_x8_sticky", 32'(g_x[2].xs), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
